mem_access_unit: RTL and testbench

//  MEM stage directly downstream of the ALU: consumes ALUOut as effective address (loads/stores) or result (other ops).

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM stage behind the ALU: formats stores, drives a req/ack data bus,
// extracts and extends load data, and returns one writeback beat per accepted op.
module mem_access_unit #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [WORD_LEN-1:0] alu_out,
  input  logic [WORD_LEN-1:0] store_data,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          funct3,
  input  logic [4:0]          rd_in,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic                dmem_ack,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  output logic                wb_valid,
  output logic [WORD_LEN-1:0] wb_data,
  output logic [4:0]          wb_rd,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  addr_lo;
  logic [2:0]  op_f3;
  logic [4:0]  op_rd;
  logic        op_load;

  function automatic logic access_fault(input logic [2:0] fn, input logic [1:0] a,
                                        input logic rd_op, input logic wr_op);
    logic bad;
    case (fn)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = a[0];
      3'b010:         bad = (a != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad | (rd_op & wr_op);
  endfunction

  // Only B/H/W sizes survive the fault check, so funct3[1:0] selects the width.
  function automatic logic [3:0] store_be(input logic [2:0] fn, input logic [1:0] a);
    logic [3:0] be;
    case (fn[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] fn, input logic [31:0] d);
    logic [31:0] w;
    case (fn[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] fn, input logic [1:0] a,
                                              input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'b00:   b = r[7:0];
      2'b01:   b = r[15:8];
      2'b10:   b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (fn)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = r;
    endcase
    return res;
  endfunction

  // Control FSM with every output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ex_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      wb_valid   <= 1'b0;
      wb_data    <= 32'd0;
      wb_rd      <= 5'd0;
      fault      <= 1'b0;
      addr_lo    <= 2'd0;
      op_f3      <= 3'd0;
      op_rd      <= 5'd0;
      op_load    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid <= 1'b0;
          if (ex_valid && ex_ready) begin
            ex_ready <= 1'b0;
            addr_lo  <= alu_out[1:0];
            op_f3    <= funct3;
            op_rd    <= rd_in;
            op_load  <= mem_read;
            if (!mem_read && !mem_write) begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_data  <= alu_out;
              wb_rd    <= rd_in;
              fault    <= 1'b0;
            end else if (access_fault(funct3, alu_out[1:0], mem_read, mem_write)) begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_data  <= 32'd0;
              wb_rd    <= 5'd0;
              fault    <= 1'b1;
            end else begin
              state      <= BUS;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_out[31:2], 2'b00};
              dmem_be    <= mem_write ? store_be(funct3, alu_out[1:0]) : 4'b1111;
              dmem_wdata <= mem_write ? store_wdata(funct3, store_data) : 32'd0;
            end
          end
        end
        BUS: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            fault    <= 1'b0;
            if (op_load) begin
              wb_data <= load_format(op_f3, addr_lo, dmem_rdata);
              wb_rd   <= op_rd;
            end else begin
              wb_data <= 32'd0;
              wb_rd   <= 5'd0;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
          ex_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
          dmem_req <= 1'b0;
          ex_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: expected writeback beats are
// queued at issue and compared when wb_valid appears.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        fault;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        flt;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  mem_access_unit #(.WORD_LEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_out(alu_out), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, play the bus slave, and check the writeback beat.
  task automatic run_op(input string tag, input logic rdop, input logic wrop,
                        input logic [2:0] fn, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int ack_delay,
                        input logic bus, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                        input logic [4:0] exp_rd, input logic exp_fault);
    wb_t e;
    chk({tag, ".ready_in"}, {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; alu_out = addr; store_data = sdata;
    mem_read = rdop; mem_write = wrop; funct3 = fn; rd_in = rd;
    sb.push_back('{data: exp_data, rd: exp_rd, flt: exp_fault});
    @(negedge clk);
    if (ack_delay == 0) ex_valid = 1'b0;
    if (bus) begin
      chk({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, wrop});
      chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({tag, ".be"}, {28'd0, dmem_be}, {28'd0, exp_be});
      if (wrop) chk({tag, ".wdata"}, dmem_wdata, exp_wdata);
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clk);
        chk({tag, ".req_hold"}, {31'd0, dmem_req}, 32'd1);
        chk({tag, ".addr_hold"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, ".be_hold"}, {28'd0, dmem_be}, {28'd0, exp_be});
        if (wrop) chk({tag, ".wdata_hold"}, dmem_wdata, exp_wdata);
        chk({tag, ".ready_busy"}, {31'd0, ex_ready}, 32'd0);
        chk({tag, ".no_early_wb"}, {31'd0, wb_valid}, 32'd0);
      end
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
    end
    ex_valid = 1'b0;
    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, ".req_off"}, {31'd0, dmem_req}, 32'd0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".wb_data"}, wb_data, e.data);
      chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
      chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e.flt});
    end
    @(negedge clk);
    chk({tag, ".wb_pulse"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".ready_again"}, {31'd0, ex_ready}, 32'd1);
    chk({tag, ".req_idle"}, {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst.ready", {31'd0, ex_ready}, 32'd1);
    chk("rst.req", {31'd0, dmem_req}, 32'd0);
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.be", {28'd0, dmem_be}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    rst = 1'b0;

    // spurious ack in IDLE is ignored
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("spur.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("spur.ready", {31'd0, ex_ready}, 32'd1);

    //      tag    rd    wr    f3      addr          sdata         rd     rdata         dly bus be       wdata         data          rd     flt
    run_op("alu",  1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,       5'd5,  32'h0,        0, 1'b0, 4'h0,   32'h0,        32'h0000_1234, 5'd5, 1'b0);
    run_op("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd7, 32'h0,       0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0,       5'd0, 1'b0);
    run_op("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,       5'd3,  32'h0080_0000, 0, 1'b1, 4'b1111, 32'h0,       32'hFFFF_FF80, 5'd3, 1'b0);
    run_op("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,       5'd4,  32'h0080_0000, 1, 1'b1, 4'b1111, 32'h0,       32'h0000_0080, 5'd4, 1'b0);
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0,     5'd9,  32'h0,        0, 1'b0, 4'h0,   32'h0,        32'h0,        5'd0, 1'b1);
    run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0,     5'd10, 32'h0,        0, 1'b0, 4'h0,   32'h0,        32'h0,        5'd0, 1'b1);
    run_op("f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,     5'd11, 32'h0,        0, 1'b0, 4'h0,   32'h0,        32'h0,        5'd0, 1'b1);
    run_op("rw_both", 1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0,    5'd12, 32'h0,        0, 1'b0, 4'h0,   32'h0,        32'h0,        5'd0, 1'b1);
    run_op("sh_slow", 1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_BEEF, 5'd13, 32'h0,  5, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,       5'd0, 1'b0);
    run_op("sw",   1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 5'd14, 32'h0,     2, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,       5'd0, 1'b0);
    run_op("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0,       5'd15, 32'h8001_7FFF, 0, 1'b1, 4'b1111, 32'h0,       32'hFFFF_8001, 5'd15, 1'b0);
    run_op("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0,       5'd16, 32'h8001_7FFF, 0, 1'b1, 4'b1111, 32'h0,       32'h0000_8001, 5'd16, 1'b0);
    run_op("lh_lo", 1'b1, 1'b0, 3'b001, 32'h0000_0004, 32'h0,      5'd17, 32'h8001_7FFF, 0, 1'b1, 4'b1111, 32'h0,       32'h0000_7FFF, 5'd17, 1'b0);
    run_op("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0,       5'd18, 32'hCAFE_F00D, 3, 1'b1, 4'b1111, 32'h0,       32'hCAFE_F00D, 5'd18, 1'b0);

    // reset while the bus is busy; the late ack must not produce a beat
    ex_valid = 1'b1; alu_out = 32'h0000_0200; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; rd_in = 5'd20;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstbus.req_on", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstbus.req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rstbus.ready", {31'd0, ex_ready}, 32'd1);
    chk("rstbus.wb_valid", {31'd0, wb_valid}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    chk("lateack.wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("lateack.wb_valid2", {31'd0, wb_valid}, 32'd0);
    chk("lateack.req", {31'd0, dmem_req}, 32'd0);

    run_op("alu2", 1'b0, 1'b0, 3'b000, 32'hFFFF_0001, 32'h0,       5'd31, 32'h0,        0, 1'b0, 4'h0,   32'h0,        32'hFFFF_0001, 5'd31, 1'b0);

    chk("sb.drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
